// File: rtl/gelato_fetch_scheduler_if.sv
// Fetch-scheduler bus: warp launch, decode/branch writeback and fetch-request handshake.
interface gelato_fetch_scheduler_if #(
  parameter int unsigned NUM_WARPS   = 8,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned SPLIT_WIDTH = 2
);
  localparam int unsigned WARP_WIDTH = $clog2(NUM_WARPS);

  logic                   launch_valid;
  logic [WARP_WIDTH-1:0]  launch_warp;
  logic [PC_WIDTH-1:0]    launch_pc;
  logic [SPLIT_WIDTH-1:0] launch_split;

  logic                   update_valid;
  logic [WARP_WIDTH-1:0]  update_warp;
  logic [PC_WIDTH-1:0]    update_pc;
  logic                   update_done;

  logic                   fetch_valid;
  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [WARP_WIDTH-1:0]  fetch_warp_num;
  logic [SPLIT_WIDTH-1:0] fetch_split_num;
  logic                   fetch_caught;

  logic [NUM_WARPS-1:0]   warp_active;

  // Environment side: launcher, writeback path and fetch unit.
  modport master (
    output launch_valid, launch_warp, launch_pc, launch_split,
    output update_valid, update_warp, update_pc, update_done,
    output fetch_caught,
    input  fetch_valid, fetch_pc, fetch_warp_num, fetch_split_num, warp_active
  );

  modport slave (
    input  launch_valid, launch_warp, launch_pc, launch_split,
    input  update_valid, update_warp, update_pc, update_done,
    input  fetch_caught,
    output fetch_valid, fetch_pc, fetch_warp_num, fetch_split_num, warp_active
  );
endinterface

// File: rtl/gelato_fetch_scheduler.sv
// Per-warp PC table with a round-robin picker offering one fetch request at a time.
module gelato_fetch_scheduler #(
  parameter int unsigned NUM_WARPS   = 8,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned SPLIT_WIDTH = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  input logic                    rdy,
  gelato_fetch_scheduler_if.slave bus
);
  localparam int unsigned WARP_WIDTH = $clog2(NUM_WARPS);

  typedef enum logic {SELECT, OFFER} state_e;

  state_e                 state_q;
  logic [NUM_WARPS-1:0]   active_q;
  logic [NUM_WARPS-1:0]   inflight_q;
  logic [PC_WIDTH-1:0]    pc_q    [NUM_WARPS];
  logic [SPLIT_WIDTH-1:0] split_q [NUM_WARPS];
  logic [WARP_WIDTH-1:0]  rr_q;

  logic                   fetch_valid_q;
  logic [PC_WIDTH-1:0]    fetch_pc_q;
  logic [WARP_WIDTH-1:0]  fetch_warp_q;
  logic [SPLIT_WIDTH-1:0] fetch_split_q;

  logic [NUM_WARPS-1:0]   eligible;
  logic                   found;
  logic [WARP_WIDTH-1:0]  sel;
  logic [WARP_WIDTH-1:0]  idx;
  logic                   launch_ok;
  logic                   update_ok;

  assign eligible  = active_q & ~inflight_q;
  assign launch_ok = bus.launch_valid && !active_q[bus.launch_warp];
  assign update_ok = bus.update_valid && active_q[bus.update_warp] && inflight_q[bus.update_warp];

  // Scan starting at rr_q; index arithmetic wraps because NUM_WARPS is a power of two.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      idx = rr_q + WARP_WIDTH'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SELECT;
      active_q      <= '0;
      inflight_q    <= '0;
      rr_q          <= '0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      fetch_warp_q  <= '0;
      fetch_split_q <= '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]    <= '0;
        split_q[w] <= '0;
      end
    end else if (rdy) begin
      if (launch_ok) begin
        active_q[bus.launch_warp]   <= 1'b1;
        inflight_q[bus.launch_warp] <= 1'b0;
        pc_q[bus.launch_warp]       <= bus.launch_pc;
        split_q[bus.launch_warp]    <= bus.launch_split;
      end
      if (update_ok) begin
        pc_q[bus.update_warp]       <= bus.update_pc;
        inflight_q[bus.update_warp] <= 1'b0;
        if (bus.update_done) active_q[bus.update_warp] <= 1'b0;
      end
      // Selection is placed last so its inflight set wins over a same-warp update clear.
      case (state_q)
        SELECT: begin
          if (found) begin
            fetch_valid_q   <= 1'b1;
            fetch_pc_q      <= pc_q[sel];
            fetch_warp_q    <= sel;
            fetch_split_q   <= split_q[sel];
            inflight_q[sel] <= 1'b1;
            rr_q            <= sel + 1'b1;
            state_q         <= OFFER;
          end
        end
        OFFER: begin
          if (bus.fetch_caught) begin
            fetch_valid_q <= 1'b0;
            state_q       <= SELECT;
          end
        end
        default: state_q <= SELECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && rdy) begin
      assert (!(bus.launch_valid && active_q[bus.launch_warp]))
        else $error("launch to already active warp %0d", bus.launch_warp);
      assert (!(bus.update_valid && !(active_q[bus.update_warp] && inflight_q[bus.update_warp])))
        else $error("update to warp %0d that is not active and in flight", bus.update_warp);
    end
  end

  assign bus.fetch_valid     = fetch_valid_q;
  assign bus.fetch_pc        = fetch_pc_q;
  assign bus.fetch_warp_num  = fetch_warp_q;
  assign bus.fetch_split_num = fetch_split_q;
  assign bus.warp_active     = active_q;

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Scoreboard bench for gelato_fetch_scheduler: expected fetches queued at stimulus, popped on offer.
module tb_gelato_fetch_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic rdy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  w;
    logic [31:0] pc;
    logic [1:0]  sp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  gelato_fetch_scheduler_if #(.NUM_WARPS(8), .PC_WIDTH(32), .SPLIT_WIDTH(2)) bus ();

  gelato_fetch_scheduler #(.NUM_WARPS(8), .PC_WIDTH(32), .SPLIT_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] w, input logic [31:0] pc, input logic [1:0] sp);
    bus.launch_valid = 1'b1;
    bus.launch_warp  = w;
    bus.launch_pc    = pc;
    bus.launch_split = sp;
    tick();
    bus.launch_valid = 1'b0;
  endtask

  task automatic update(input logic [2:0] w, input logic [31:0] pc, input logic done);
    bus.update_valid = 1'b1;
    bus.update_warp  = w;
    bus.update_pc    = pc;
    bus.update_done  = done;
    tick();
    bus.update_valid = 1'b0;
    bus.update_done  = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!bus.fetch_valid && n < 40) begin
      tick();
      n++;
    end
    ok = bus.fetch_valid;
  endtask

  // Waits for an offer, compares it with the scoreboard head, then accepts it.
  task automatic catch_one(input string name);
    bit   ok;
    exp_t e;
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no fetch_valid within bound, got fetch_valid=%0b required 1", name, bus.fetch_valid);
      return;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected offer warp=%0d pc=%h, required no offer", name, bus.fetch_warp_num, bus.fetch_pc);
    end else begin
      e = sb.pop_front();
      if ({bus.fetch_warp_num, bus.fetch_pc, bus.fetch_split_num} !== {e.w, e.pc, e.sp})
      begin
        errors++;
        $display("FAIL %s: got warp=%0d pc=%h split=%0d required warp=%0d pc=%h split=%0d",
                 name, bus.fetch_warp_num, bus.fetch_pc, bus.fetch_split_num, e.w, e.pc, e.sp);
      end
    end
    bus.fetch_caught = 1'b1;
    tick();
    bus.fetch_caught = 1'b0;
    checks++;
    if (bus.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drop: fetch_valid=%0b after catch, required 0", name, bus.fetch_valid);
    end
  endtask

  task automatic expect_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (bus.fetch_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s: fetch_valid=%0b warp=%0d, required 0", name, bus.fetch_valid, bus.fetch_warp_num);
      end
    end
  endtask

  task automatic check_active(input string name, input logic [7:0] exp);
    checks++;
    if (bus.warp_active !== exp) begin
      errors++;
      $display("FAIL %s: warp_active=%b required %b", name, bus.warp_active, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rdy   = 1'b1;
    bus.launch_valid = 1'b0; bus.launch_warp = '0; bus.launch_pc = '0; bus.launch_split = '0;
    bus.update_valid = 1'b0; bus.update_warp = '0; bus.update_pc = '0; bus.update_done = 1'b0;
    bus.fetch_caught = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.fetch_valid, bus.fetch_pc, bus.fetch_warp_num, bus.fetch_split_num, bus.warp_active} !== '0) begin
      errors++;
      $display("FAIL reset: valid=%0b pc=%h warp=%0d split=%0d active=%b, required all 0",
               bus.fetch_valid, bus.fetch_pc, bus.fetch_warp_num, bus.fetch_split_num, bus.warp_active);
    end
    expect_idle("reset_idle", 3);
  endtask

  task automatic test_single();
    launch(3'd3, 32'h100, 2'd1);
    sb.push_back('{w: 3'd3, pc: 32'h100, sp: 2'd1});
    check_active("single_active", 8'h08);
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: fetch_valid=%0b two cycles after launch, required 1", bus.fetch_valid);
    end
    tick(); tick();
    catch_one("single");
    update(3'd3, 32'h104, 1'b1);
    check_active("single_exit", 8'h00);
  endtask

  task automatic test_round_robin();
    launch(3'd0, 32'h1000, 2'd0);
    launch(3'd2, 32'h2000, 2'd2);
    launch(3'd5, 32'h3000, 2'd3);
    sb.push_back('{w: 3'd0, pc: 32'h1000, sp: 2'd0});
    sb.push_back('{w: 3'd2, pc: 32'h2000, sp: 2'd2});
    sb.push_back('{w: 3'd5, pc: 32'h3000, sp: 2'd3});
    check_active("rr_active", 8'h25);
    catch_one("rr_w0");
    update(3'd0, 32'h1004, 1'b0);
    sb.push_back('{w: 3'd0, pc: 32'h1004, sp: 2'd0});
    catch_one("rr_w2");
    update(3'd2, 32'h2004, 1'b0);
    sb.push_back('{w: 3'd2, pc: 32'h2004, sp: 2'd2});
    catch_one("rr_w5");
    update(3'd5, 32'h3004, 1'b0);
    sb.push_back('{w: 3'd5, pc: 32'h3004, sp: 2'd3});
    catch_one("rr2_w0");
    catch_one("rr2_w2");
    catch_one("rr2_w5");
  endtask

  task automatic test_no_update();
    update(3'd0, 32'h1008, 1'b0);
    sb.push_back('{w: 3'd0, pc: 32'h1008, sp: 2'd0});
    update(3'd5, 32'h3008, 1'b0);
    sb.push_back('{w: 3'd5, pc: 32'h3008, sp: 2'd3});
    catch_one("noupd_w0");
    catch_one("noupd_w5");
    expect_idle("blocked_w2", 8);
    update(3'd2, 32'h200, 1'b0);
    sb.push_back('{w: 3'd2, pc: 32'h200, sp: 2'd2});
    catch_one("w2_resume");
  endtask

  task automatic test_exit();
    update(3'd0, 32'h0, 1'b1);
    check_active("exit_w0", 8'h24);
    update(3'd5, 32'h0, 1'b1);
    update(3'd2, 32'h0, 1'b1);
    check_active("exit_all", 8'h00);
    expect_idle("exit_idle", 6);
    launch(3'd0, 32'h40, 2'd1);
    sb.push_back('{w: 3'd0, pc: 32'h40, sp: 2'd1});
    check_active("relaunch", 8'h01);
    catch_one("relaunch_w0");
    update(3'd0, 32'h44, 1'b1);
  endtask

  task automatic test_hold_freeze();
    bit ok;
    launch(3'd6, 32'h600, 2'd3);
    sb.push_back('{w: 3'd6, pc: 32'h600, sp: 2'd3});
    wait_valid(ok);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus.fetch_valid, bus.fetch_warp_num, bus.fetch_pc} !== {1'b1, 3'd6, 32'h600}) begin
        errors++;
        $display("FAIL hold: valid=%0b warp=%0d pc=%h, required 1/6/00000600",
                 bus.fetch_valid, bus.fetch_warp_num, bus.fetch_pc);
      end
    end
    rdy = 1'b0;
    bus.fetch_caught = 1'b1;
    bus.launch_valid = 1'b1; bus.launch_warp = 3'd1; bus.launch_pc = 32'h11; bus.launch_split = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.fetch_valid, bus.fetch_warp_num, bus.fetch_pc, bus.warp_active} !== {1'b1, 3'd6, 32'h600, 8'h40}) begin
        errors++;
        $display("FAIL freeze: valid=%0b warp=%0d pc=%h active=%b, required 1/6/00000600/01000000",
                 bus.fetch_valid, bus.fetch_warp_num, bus.fetch_pc, bus.warp_active);
      end
    end
    bus.launch_valid = 1'b0;
    bus.fetch_caught = 1'b0;
    rdy = 1'b1;
    catch_one("freeze_w6");
    update(3'd6, 32'h0, 1'b1);
    check_active("freeze_exit", 8'h00);
  endtask

  task automatic test_wrap();
    bit ok;
    launch(3'd6, 32'h660, 2'd0);
    wait_valid(ok);
    launch(3'd0, 32'h10, 2'd1);
    launch(3'd7, 32'h70, 2'd2);
    sb.push_back('{w: 3'd6, pc: 32'h660, sp: 2'd0});
    sb.push_back('{w: 3'd7, pc: 32'h70, sp: 2'd2});
    sb.push_back('{w: 3'd0, pc: 32'h10, sp: 2'd1});
    catch_one("wrap_w6");
    catch_one("wrap_w7");
    catch_one("wrap_w0");
    update(3'd6, 32'h0, 1'b1);
    update(3'd7, 32'h0, 1'b1);
    update(3'd0, 32'h0, 1'b1);
    check_active("wrap_exit", 8'h00);
  endtask

  task automatic test_reset_mid_offer();
    bit ok;
    launch(3'd4, 32'h400, 2'd2);
    wait_valid(ok);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.fetch_valid, bus.warp_active} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset: fetch_valid=%0b warp_active=%b, required 0/00000000",
               bus.fetch_valid, bus.warp_active);
    end
    sb.delete();
    tick();
    rst_n = 1'b1;
    expect_idle("post_reset_idle", 4);
    check_active("post_reset_active", 8'h00);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_update();
    test_exit();
    test_hold_freeze();
    test_wrap();
    test_reset_mid_offer();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected fetches never offered, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
